// File: rtl/maxpool2x2_stream_pkg.sv
// Types and helpers for the 2x2 stride-2 pooling stage.
// fp_gt orders IEEE words by sign-magnitude with -0 == +0.
package maxpool2x2_stream_pkg;

    import params_pkg::*;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_HOLD,
        OP_LINE,
        OP_VERT,
        OP_OUT
    } op_t;

    function automatic logic fp_gt(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic                  sa;
        logic                  sb;
        logic [DATA_WIDTH-2:0] ma;
        logic [DATA_WIDTH-2:0] mb;
        logic                  zz;
        logic                  r;
        sa = a[DATA_WIDTH-1];
        sb = b[DATA_WIDTH-1];
        ma = a[DATA_WIDTH-2:0];
        mb = b[DATA_WIDTH-2:0];
        zz = (ma == '0) && (mb == '0);
        r  = 1'b0;
        unique case ({sa, sb})
            2'b00:   r = ma > mb;
            2'b11:   r = ma < mb;
            2'b01:   r = !zz;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/params.sv
// Shared numeric parameters for the pooling datapath.
// Pool mode encodings live beside the word width.
package params_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int POOL_MAX   = 0;
    localparam int POOL_MIN   = 1;

endpackage

// File: rtl/maxpool2x2_stream_if.sv
// Stream bus of the pooling stage: input strobe/word, pooled output.
// slave is the pooling block, master is whoever feeds and drains it.
interface maxpool2x2_stream_if;

    import params_pkg::*;

    logic                  valid_in;
    logic [DATA_WIDTH-1:0] data;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  frame_done;

    modport master (
        output valid_in,
        output data,
        input  data_out,
        input  valid_out,
        input  frame_done
    );

    modport slave (
        input  valid_in,
        input  data,
        output data_out,
        output valid_out,
        output frame_done
    );

endinterface

// File: rtl/maxpool2x2_stream_cmp.sv
// Combinational 2-input IEEE max/min select (fp_cmp_sel).
// Ties, including -0 vs +0, return operand a.
module fp_cmp_sel
    import params_pkg::*;
    import maxpool2x2_stream_pkg::*;
#(
    parameter int MODE = POOL_MAX
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y
);

    logic take_b;

    always_comb begin
        take_b = 1'b0;
        if (MODE == POOL_MAX) take_b = fp_gt(b, a);
        else                  take_b = fp_gt(a, b);
        y = take_b ? b : a;
    end

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 max/min pooling over raster, channel-interleaved
// pixels, keeping only a half-row of partial results.
module maxpool2x2_stream
    import params_pkg::*;
    import maxpool2x2_stream_pkg::*;
#(
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28,
    parameter int CHANNELS   = 1,
    parameter int MODE       = POOL_MAX
) (
    input logic               clk,
    input logic               rst,
    maxpool2x2_stream_if.slave bus
);

    localparam int WW     = $clog2(IMG_WIDTH);
    localparam int HW     = $clog2(IMG_HEIGHT);
    localparam int CW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int KW     = (IMG_WIDTH / 2) * 2;
    localparam int KH     = (IMG_HEIGHT / 2) * 2;
    localparam int LBUF_N = (IMG_WIDTH / 2) * CHANNELS;
    localparam int IW     = (LBUF_N > 1) ? $clog2(LBUF_N) : 1;

    logic [WW-1:0] col;
    logic [HW-1:0] row;
    logic [CW-1:0] ch;

    logic [DATA_WIDTH-1:0] hbuf [CHANNELS];
    logic [DATA_WIDTH-1:0] lbuf [LBUF_N];

    logic [IW-1:0]         idx;
    logic                  drop;
    logic                  last;
    op_t                   op;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_y;

    // Odd trailing column/row are counted but never enter a window.
    always_comb begin
        drop = ((IMG_WIDTH % 2) == 1 && col == WW'(IMG_WIDTH - 1))
            || ((IMG_HEIGHT % 2) == 1 && row == HW'(IMG_HEIGHT - 1));
        last = (row == HW'(KH - 1)) && (col == WW'(KW - 1))
            && (ch == CW'(CHANNELS - 1));
        idx  = IW'(int'(col >> 1) * CHANNELS + int'(ch));
    end

    always_comb begin
        op = OP_NONE;
        if (bus.valid_in && !rst && !drop) begin
            unique case (1'b1)
                !row[0] && !col[0]: op = OP_HOLD;
                !row[0] &&  col[0]: op = OP_LINE;
                 row[0] && !col[0]: op = OP_VERT;
                default:            op = OP_OUT;
            endcase
        end
    end

    // One comparator serves every case; only the vertical step reads lbuf.
    assign sel_a = (op == OP_VERT) ? lbuf[idx] : hbuf[ch];

    fp_cmp_sel #(
        .MODE (MODE)
    ) u_sel (
        .a (sel_a),
        .b (bus.data),
        .y (sel_y)
    );

    always_ff @(posedge clk) begin
        unique case (op)
            OP_HOLD: hbuf[ch]  <= bus.data;
            OP_VERT: hbuf[ch]  <= sel_y;
            OP_LINE: lbuf[idx] <= sel_y;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col            <= '0;
            row            <= '0;
            ch             <= '0;
            bus.data_out   <= '0;
            bus.valid_out  <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.valid_out  <= (op == OP_OUT);
            bus.frame_done <= (op == OP_OUT) && last;
            if (op == OP_OUT) bus.data_out <= sel_y;
            if (bus.valid_in) begin
                if (ch == CW'(CHANNELS - 1)) begin
                    ch <= '0;
                    if (col == WW'(IMG_WIDTH - 1)) begin
                        col <= '0;
                        if (row == HW'(IMG_HEIGHT - 1)) row <= '0;
                        else                           row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end else begin
                    ch <= ch + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Bench for maxpool2x2_stream: four geometries against a window model.
// Literal expectations pin the model on the hand-worked frames.
module tb_maxpool2x2_stream;

    import params_pkg::*;

    logic clk = 1'b0;
    logic ra, rb, rc, rd;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc_n = 0;
    bit   started = 0;

    always #5 clk = ~clk;

    maxpool2x2_stream_if ifa ();
    maxpool2x2_stream_if ifb ();
    maxpool2x2_stream_if ifc ();
    maxpool2x2_stream_if ifd ();

    maxpool2x2_stream #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .CHANNELS(1), .MODE(POOL_MAX))
        u_a (.clk(clk), .rst(ra), .bus(ifa));
    maxpool2x2_stream #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .CHANNELS(1), .MODE(POOL_MIN))
        u_b (.clk(clk), .rst(rb), .bus(ifb));
    maxpool2x2_stream #(.IMG_WIDTH(2), .IMG_HEIGHT(2), .CHANNELS(2), .MODE(POOL_MAX))
        u_c (.clk(clk), .rst(rc), .bus(ifc));
    maxpool2x2_stream #(.IMG_WIDTH(5), .IMG_HEIGHT(3), .CHANNELS(1), .MODE(POOL_MAX))
        u_d (.clk(clk), .rst(rd), .bus(ifd));

    int gw [4] = '{4, 4, 2, 5};
    int gh [4] = '{4, 4, 2, 3};
    int gc [4] = '{1, 1, 2, 1};
    int gm [4] = '{0, 1, 0, 0};

    int          mpos [4];
    logic        ev   [4];
    logic        ef   [4];
    logic [31:0] ed   [4];
    logic [31:0] pix  [4][32];

    logic [63:0] cap_a [$];
    logic [63:0] cap_b [$];
    logic [63:0] cap_c [$];
    logic [63:0] cap_d [$];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Signed integer key: sign-magnitude order, both zeros map to 0.
    function automatic logic [31:0] ref_sel(int mode, logic [31:0] a, logic [31:0] b);
        longint ka, kb;
        ka = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
        kb = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
        if (mode == 0) return (kb > ka) ? b : a;
        return (kb < ka) ? b : a;
    endfunction

    function automatic logic [31:0] f32(int n);
        int          e;
        logic [31:0] m;
        if (n == 0) return 32'h0;
        e = 0;
        for (int i = 0; i < 24; i++) if (n[i]) e = i;
        m = 32'(n) << (23 - e);
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    task automatic model_step(int k, logic r, logic v, logic [31:0] d);
        int w, h, n, c, x, y;
        logic [31:0] p0, p1, p2;
        w = gw[k]; h = gh[k]; n = gc[k];
        ev[k] = 1'b0;
        ef[k] = 1'b0;
        if (r) begin
            mpos[k] = 0;
            ed[k]   = 32'h0;
        end else if (v) begin
            pix[k][mpos[k]] = d;
            c = mpos[k] % n;
            x = (mpos[k] / n) % w;
            y = mpos[k] / (n * w);
            if (y % 2 == 1 && x % 2 == 1 && x < (w / 2) * 2 && y < (h / 2) * 2) begin
                p0 = pix[k][((y - 1) * w + x - 1) * n + c];
                p1 = pix[k][((y - 1) * w + x) * n + c];
                p2 = pix[k][(y * w + x - 1) * n + c];
                ed[k] = ref_sel(gm[k], ref_sel(gm[k], ref_sel(gm[k], p0, p1), p2), d);
                ev[k] = 1'b1;
                ef[k] = (y == (h / 2) * 2 - 1) && (x == (w / 2) * 2 - 1) && (c == n - 1);
            end
            mpos[k] = (mpos[k] + 1 == w * h * n) ? 0 : mpos[k] + 1;
        end
    endtask

    always @(posedge clk) begin
        cyc_n++;
        model_step(0, ra, ifa.valid_in, ifa.data);
        model_step(1, rb, ifb.valid_in, ifb.data);
        model_step(2, rc, ifc.valid_in, ifc.data);
        model_step(3, rd, ifd.valid_in, ifd.data);
        started = 1;
    end

    task automatic cmp_out(int k, string nm, logic v, logic f, logic [31:0] d);
        chk({nm, "_valid_out"}, 64'(v), 64'(ev[k]));
        chk({nm, "_frame_done"}, 64'(f), 64'(ef[k]));
        chk({nm, "_data_out"}, 64'(d), 64'(ed[k]));
    endtask

    always @(negedge clk) begin
        if (started) begin
            cmp_out(0, "a", ifa.valid_out, ifa.frame_done, ifa.data_out);
            cmp_out(1, "b", ifb.valid_out, ifb.frame_done, ifb.data_out);
            cmp_out(2, "c", ifc.valid_out, ifc.frame_done, ifc.data_out);
            cmp_out(3, "d", ifd.valid_out, ifd.frame_done, ifd.data_out);
            if (ifa.valid_out) cap_a.push_back({31'(cyc_n), ifa.frame_done, ifa.data_out});
            if (ifb.valid_out) cap_b.push_back({31'(cyc_n), ifb.frame_done, ifb.data_out});
            if (ifc.valid_out) cap_c.push_back({31'(cyc_n), ifc.frame_done, ifc.data_out});
            if (ifd.valid_out) cap_d.push_back({31'(cyc_n), ifd.frame_done, ifd.data_out});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(int k, logic v, logic [31:0] d);
        case (k)
            0: begin ifa.valid_in = v; ifa.data = d; end
            1: begin ifb.valid_in = v; ifb.data = d; end
            2: begin ifc.valid_in = v; ifc.data = d; end
            default: begin ifd.valid_in = v; ifd.data = d; end
        endcase
    endtask

    task automatic set_rst(int k, logic r);
        case (k)
            0: ra = r;
            1: rb = r;
            2: rc = r;
            default: rd = r;
        endcase
    endtask

    // Pops the next captured output and checks {frame_done, data}.
    task automatic lit(int k, string nm, logic fd, logic [31:0] d, output int at);
        logic [63:0] e;
        at = -1;
        case (k)
            0: if (cap_a.size() > 0) e = cap_a.pop_front(); else e = '1;
            1: if (cap_b.size() > 0) e = cap_b.pop_front(); else e = '1;
            2: if (cap_c.size() > 0) e = cap_c.pop_front(); else e = '1;
            default: if (cap_d.size() > 0) e = cap_d.pop_front(); else e = '1;
        endcase
        if (e == '1) begin
            chk({nm, "_missing"}, 64'd0, 64'd1);
        end else begin
            chk(nm, 64'(e[32:0]), 64'({fd, d}));
            at = int'(e[63:33]);
        end
    endtask

    task automatic no_extra(int k, string nm);
        int s;
        case (k)
            0: s = cap_a.size();
            1: s = cap_b.size();
            2: s = cap_c.size();
            default: s = cap_d.size();
        endcase
        chk({nm, "_extra_outputs"}, 64'(s), 64'd0);
    endtask

    task automatic clear_caps();
        cap_a.delete();
        cap_b.delete();
        cap_c.delete();
        cap_d.delete();
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        logic [31:0] z [4];
        z = '{32'h0, 32'h8000_0000, 32'h3F80_0000, 32'hBF80_0000};
        case ($urandom_range(0, 3))
            0: w = z[$urandom_range(0, 3)];
            1: w = f32(int'($urandom_range(0, 20))) | {$urandom_range(0, 1) == 1, 31'h0};
            default: w = $urandom;
        endcase
        return w;
    endfunction

    task automatic rand_frames(int k, int frames);
        int n;
        n = gw[k] * gh[k] * gc[k];
        for (int f = 0; f < frames; f++) begin
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 2) == 0) cyc();
                set_in(k, 1'b1, rand_word());
                if (k == 3 && f == 1 && i == 6) set_rst(k, 1'b1);
                cyc();
                set_rst(k, 1'b0);
                set_in(k, 1'b0, 32'h0);
            end
        end
        repeat (3) cyc();
    endtask

    logic [31:0] c_f1 [8];
    logic [31:0] c_f2 [8];
    int t0, t1, tmp;

    initial begin
        c_f1 = '{32'h3F80_0000, 32'hBF00_0000, 32'hC000_0000, 32'h3E80_0000,
                 32'h4040_0000, 32'hC100_0000, 32'hC080_0000, 32'h40F0_0000};
        c_f2 = '{32'hC040_0000, 32'h0000_0000, 32'hBF80_0000, 32'h8000_0000,
                 32'h8000_0000, 32'hC0A0_0000, 32'hC000_0000, 32'hC0C0_0000};
        ra = 1; rb = 1; rc = 1; rd = 1;
        for (int k = 0; k < 4; k++) set_in(k, 1'b0, 32'h0);
        repeat (3) cyc();
        chk("reset_data_out", 64'(ifa.data_out), 64'h0);
        chk("reset_valid_out", 64'(ifa.valid_out), 64'h0);
        chk("reset_frame_done", 64'(ifd.frame_done), 64'h0);
        ra = 0; rb = 0; rc = 0; rd = 0;
        cyc();

        for (int i = 1; i <= 16; i++) begin
            set_in(0, 1'b1, f32(i));
            set_in(1, 1'b1, f32(i));
            cyc();
        end
        set_in(0, 1'b0, 32'h0);
        set_in(1, 1'b0, 32'h0);
        repeat (3) cyc();
        lit(0, "max4x4_0", 1'b0, 32'h40C0_0000, tmp);
        lit(0, "max4x4_1", 1'b0, 32'h4100_0000, tmp);
        lit(0, "max4x4_2", 1'b0, 32'h4160_0000, tmp);
        lit(0, "max4x4_3", 1'b1, 32'h4180_0000, tmp);
        lit(1, "min4x4_0", 1'b0, 32'h3F80_0000, tmp);
        lit(1, "min4x4_1", 1'b0, 32'h4040_0000, tmp);
        lit(1, "min4x4_2", 1'b0, 32'h4110_0000, tmp);
        lit(1, "min4x4_3", 1'b1, 32'h4130_0000, tmp);
        no_extra(0, "max4x4");
        no_extra(1, "min4x4");

        for (int i = 0; i < 8; i++) begin set_in(2, 1'b1, c_f1[i]); cyc(); end
        for (int i = 0; i < 8; i++) begin set_in(2, 1'b1, c_f2[i]); cyc(); end
        set_in(2, 1'b0, 32'h0);
        repeat (3) cyc();
        lit(2, "ch2_a", 1'b0, 32'h4040_0000, t0);
        lit(2, "ch2_b", 1'b1, 32'h40F0_0000, t1);
        chk("ch2_consecutive", 64'(t1 - t0), 64'd1);
        lit(2, "neg_zero", 1'b0, 32'h8000_0000, tmp);
        lit(2, "pos_zero_tie", 1'b1, 32'h0000_0000, tmp);
        no_extra(2, "ch2");

        for (int f = 0; f < 2; f++)
            for (int i = 1; i <= 15; i++) begin set_in(3, 1'b1, f32(i)); cyc(); end
        set_in(3, 1'b0, 32'h0);
        repeat (3) cyc();
        for (int f = 0; f < 2; f++) begin
            lit(3, "odd_7", 1'b0, 32'h40E0_0000, tmp);
            lit(3, "odd_9", 1'b1, 32'h4110_0000, tmp);
        end
        no_extra(3, "odd5x3");

        for (int i = 1; i <= 16; i++) begin
            set_in(0, 1'b1, f32(i)); cyc();
            set_in(0, 1'b0, 32'h0); cyc();
        end
        repeat (2) cyc();
        lit(0, "gap_0", 1'b0, 32'h40C0_0000, tmp);
        lit(0, "gap_1", 1'b0, 32'h4100_0000, tmp);
        lit(0, "gap_2", 1'b0, 32'h4160_0000, tmp);
        lit(0, "gap_3", 1'b1, 32'h4180_0000, tmp);
        no_extra(0, "gap");

        for (int i = 1; i <= 9; i++) begin set_in(0, 1'b1, f32(i)); cyc(); end
        ra = 1;
        set_in(0, 1'b1, 32'h42C6_0000);
        cyc();
        ra = 0;
        set_in(0, 1'b0, 32'h0);
        cyc();
        clear_caps();
        for (int i = 1; i <= 16; i++) begin set_in(0, 1'b1, f32(i)); cyc(); end
        set_in(0, 1'b0, 32'h0);
        repeat (3) cyc();
        lit(0, "rst_0", 1'b0, 32'h40C0_0000, tmp);
        lit(0, "rst_1", 1'b0, 32'h4100_0000, tmp);
        lit(0, "rst_2", 1'b0, 32'h4160_0000, tmp);
        lit(0, "rst_3", 1'b1, 32'h4180_0000, tmp);
        no_extra(0, "rst");

        for (int k = 0; k < 4; k++) rand_frames(k, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/maxpool2x2_stream.md
# maxpool2x2_stream

Streaming 2x2, stride-2 floating-point pooling stage with parametrised image width, height and channel count. It consumes one raster-ordered, channel-interleaved pixel per `valid_in` and emits one pooled value per window. Windows are non-overlapping. It holds half a row of partial results instead of full lines, and flags end of frame. It sits between a convolution/activation stage and the next layer, running off the same `valid_in` strobe scheme.

## Interface
- `DATA_WIDTH`, from `params.sv` (32): IEEE-754 word width.
- `IMG_WIDTH`, 28: input columns per row, must be ≥ 2.
- `IMG_HEIGHT`, 28: input rows per frame, must be ≥ 2.
- `CHANNELS`, 1: channels interleaved per pixel (channel index innermost).
- `MODE`, 0: 0 = max pooling, 1 = min pooling (static).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `valid_in`  in  1  `data` is the next stream word this cycle.
- `data`  in  DATA_WIDTH  input sample.
- `data_out`  out  DATA_WIDTH  pooled result, registered.
- `valid_out`  out  1  `data_out` valid this cycle, one-cycle pulse.
- `frame_done`  out  1  pulses together with the last `valid_out` of a frame.

## Operation
- Counters: `ch` (0..CHANNELS-1), `col` (0..IMG_WIDTH-1), `row` (0..IMG_HEIGHT-1).
  - Counters advance only on `valid_in`; `ch` is fastest.
  - All counters wrap to 0 after the last word of a frame; the next frame follows with no gap required.
- Odd dimensions: the trailing column (`col` = IMG_WIDTH-1 when IMG_WIDTH is odd) and trailing row are consumed and counted but discarded.
- Output count per frame is (IMG_WIDTH/2)·(IMG_HEIGHT/2)·CHANNELS, using integer division.
- Storage:
  - `hbuf[CHANNELS]`: horizontal hold registers.
  - `lbuf[(IMG_WIDTH/2)·CHANNELS]`: half-row buffer, indexed by `(col>>1)·CHANNELS + ch`.
- Even row, even col: `hbuf[ch] ← data`.
- Even row, odd col: `lbuf[idx] ← sel(hbuf[ch], data)`.
- Odd row, even col: `hbuf[ch] ← sel(lbuf[idx], data)`.
- Odd row, odd col: `data_out ← sel(hbuf[ch], data)`, and `valid_out ← 1`.
- `sel` is max when MODE=0 and min when MODE=1, using IEEE sign-magnitude ordering:
  - −0 and +0 compare equal; on a tie, the first operand is returned.
  - NaN receives no special handling: it is ordered by its bit pattern as a magnitude.
- `frame_done` = `valid_out` for the window with the last kept row, last kept col and `ch` = CHANNELS-1.
- No backpressure. The downstream block must accept every `valid_out`.

## Timing
- Reset: `data_out`=0, `valid_out`=0, `frame_done`=0, all counters 0. `hbuf` and `lbuf` contents are don't-care.
- Latency: `valid_out` asserts in the cycle after the `valid_in` of the window's bottom-right sample.
- `valid_in` low: counters, buffers and `data_out` all hold. `valid_out` and `frame_done` deassert in the next cycle.
- `rst` mid-frame: the partial frame is abandoned. The first `valid_in` after reset is treated as pixel (0,0,ch0).
- `rst` and `valid_in` in the same cycle: reset wins and the sample is dropped.
- Back-to-back frames: the `frame_done` cycle may coincide with acceptance of pixel (0,0) of the next frame.
- `lbuf` read and write are both on the current cycle's index.
  - It is implemented as registers or a single-port RAM with asynchronous read.
  - It is never read and written in the same cycle.

## Structure
- `params.sv` supplies DATA_WIDTH. The MODE encodings (`POOL_MAX`=0, `POOL_MIN`=1) are added there as localparams.
- Sub-module `fp_cmp_sel`: a combinational 2-input IEEE select that takes MODE as a parameter. It is instantiated once and shared by all four datapath cases via operand muxing.
- The top module holds the counters, `hbuf`, `lbuf` and output registers.

## Test plan
- **4×4×1 max:** send rows {1,2,3,4}, {5,6,7,8}, {9,10,11,12}, {13,14,15,16} as floats.
  - Required: outputs 6.0, 8.0, 14.0, 16.0, one cycle after samples 6, 8, 14 and 16.
  - Required: `frame_done` with 16.0.
- **MODE=1, same stimulus:** required outputs 1.0, 3.0, 9.0, 11.0.
- **CHANNELS=2, 2×2, interleaved (a0,b0,a1,b1,…):**
  - ch0 = {1.0, −2.0, 3.0, −4.0}, ch1 = {−0.5, 0.25, −8.0, 7.5}.
  - Required: 3.0 then 7.5 on consecutive cycles; `frame_done` with 7.5.
- **5×3×1 with 1.0 to 15.0 sequential, MODE=0:** required exactly two outputs, 7.0 and 9.0; column 5 and row 3 are discarded. Then a second frame of the same stimulus, with no idle cycle, must produce the same two outputs.
- **Gapped input plus mid-frame reset:**
  - Repeat the 4×4 case with `valid_in` toggling every other cycle: outputs unchanged, each `valid_out` one cycle after its sample.
  - Assert `rst` after 9 samples, then resend the full frame: required exactly 6.0, 8.0, 14.0, 16.0.
- **Signed values:** window {−3.0, −1.0, −0.0, −2.0}, MODE=0 → −0.0 (0x80000000). Window {+0.0, −0.0, −5.0, −6.0} → +0.0 (first operand on the tie).
